uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Debug/loader bus initiator. Turns framed byte commands from the UART receiver into single Wishbone-style read/write cycles on the system bus (STB/WE/ADDR/DAT/ACK).
- Returns a status byte, plus read data for reads, through the UART transmitter.
- Sits beside the CPU as a second master. Lets the host PC load RAM/VRAM and poke the disk/counter/keyboard slaves without the CPU running.

Parameters:
- ACK_TIMEOUT, 1024, clk cycles STB may stay high without ACK before the cycle is aborted (min 2).
- RX_GAP_TIMEOUT, 5000000, clk cycles of RX silence mid-frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock (clk100 domain)
- RSTN  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from uart
- rx_done  in  1  one-cycle pulse: rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse: send tx_data
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse: byte fully sent
- STB  out  1  bus strobe
- WE  out  1  bus write enable
- ADDR  out  32  bus address
- DAT_O  out  32  write data
- DAT_I  in  32  read data
- ACK  in  1  slave acknowledge
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, RSTN=0):
  - outputs: STB=0, WE=0, ADDR=0, DAT_O=0, tx_data=0, tx_start=0.
  - internal: state=IDLE, byte counters=0, gap counter=0.
  - Reset mid-bus-cycle drops STB immediately. No response byte is sent.
- Frame format:
  - Byte 0: opcode, 0x52 'R' or 0x57 'W'.
  - Bytes 1-4: address, MSB first.
  - 'W' only: bytes 5-8 data, MSB first.
  - Only rx_done-qualified bytes are counted.
- States: IDLE -> ADDR -> (DATA if W) -> BUS -> RESP -> IDLE.
- IDLE:
  - rx_done with 0x52/0x57: latch op, go to ADDR.
  - Any other byte: queue response 0x3F '?' and go to RESP.
- ADDR and DATA:
  - Each byte shifts into a 32-bit register, left shift by 8, byte in LSBs.
  - A 2-bit counter selects the 4th byte as the last.
  - Address/data registers drive ADDR/DAT_O only while in BUS.
- Gap timeout:
  - A gap counter runs in ADDR/DATA and clears on every rx_done.
  - At RX_GAP_TIMEOUT it returns to IDLE silently. No bus cycle, no response.
- BUS:
  - STB=1 in the cycle after the final frame byte's rx_done.
  - WE=1 for 'W'. ADDR and DAT_O are stable for the whole time STB=1.
  - On the first cycle with STB=1 and ACK=1:
    - for reads, DAT_I is captured;
    - STB and WE drop to 0 the next cycle.
  - Single-cycle ACK slaves (ACK tied 1) give exactly one STB-high cycle.
  - ACK is ignored while STB=0.
  - Timeout counter clears on BUS entry. When it reaches ACK_TIMEOUT with no ACK, STB drops and the response is 0x45 'E'.
- RESP response sequences:
  - write ok: 0x4B 'K'
  - read ok: 0x4B, then 4 data bytes MSB first
  - timeout: 0x45
  - bad opcode: 0x3F
- RESP byte handshake:
  - tx_start pulses for exactly one cycle with tx_data valid, only when tx_busy=0.
  - tx_data is held until the matching tx_done.
  - Next byte starts no earlier than the cycle after tx_done.
  - After the last tx_done, return to IDLE.
- rx_done arriving during BUS or RESP is ignored (byte dropped). The host must wait for the response.
- rx_done in the same cycle as the gap-timeout expiry: the byte is accepted and the timeout is cancelled.
- rx_done in the same cycle as the RESP->IDLE transition: the byte is ignored.
- Address is passed through unaligned. Slaves use ADDR[..:2].

Test Plan:
- Reset: hold RSTN=0 while driving rx_done pulses -> STB=0, tx_start=0, busy=0. Release, then send 'W',00,00,00,10,DE,AD,BE,EF with ACK tied 1 -> exactly one cycle of STB=1, WE=1, ADDR=0x00000010, DAT_O=0xDEADBEEF, then one tx byte 0x4B.
- Read, ACK tied 1, DAT_I=0x12345678: send 'R',00,00,00,10 -> one STB cycle with WE=0, then tx bytes 4B,12,34,56,78 in order. Each tx_start comes only after the previous tx_done.
- Delayed ACK: ACK asserts 7 cycles after STB -> STB high for exactly 7 cycles and ADDR stable throughout. Then ACK held 0 (ACK_TIMEOUT=16) -> STB drops after 16 cycles and the response is 0x45.
- Bad opcode 0x41 -> response 0x3F, no STB. Next a valid 'R' frame is processed normally.
- Gap abort (RX_GAP_TIMEOUT=100): send 'W',00,00 then silence for 100 cycles -> back to IDLE, no STB, no tx. A fresh full frame then works.
- Extra byte during RESP: send 0x55 while 4B is transmitting -> ignored. Response completes unchanged. Reset asserted during BUS -> STB=0 in the same cycle, no tx.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes 'R'/'W' byte frames into single bus cycles
// and answers with a status byte (plus read data) over the UART transmitter.
module uart_bus_master #(
  parameter int ACK_TIMEOUT    = 1024,
  parameter int RX_GAP_TIMEOUT = 5000000
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADDR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK,
  output logic        busy
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(RX_GAP_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(RX_GAP_TIMEOUT - 1);

  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t          state;
  logic            op_wr;
  logic [1:0]      byte_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [AW-1:0]   ack_cnt;
  logic [31:0]     addr_sr;
  logic [31:0]     data_sr;
  logic [39:0]     resp_sr;
  logic [2:0]      resp_left;
  logic            tx_wait;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      byte_cnt  <= 2'd0;
      gap_cnt   <= '0;
      ack_cnt   <= '0;
      addr_sr   <= 32'h0;
      data_sr   <= 32'h0;
      resp_sr   <= 40'h0;
      resp_left <= 3'd0;
      tx_wait   <= 1'b0;
      tx_data   <= 8'h0;
      tx_start  <= 1'b0;
      STB       <= 1'b0;
      WE        <= 1'b0;
      ADDR      <= 32'h0;
      DAT_O     <= 32'h0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          byte_cnt <= 2'd0;
          gap_cnt  <= '0;
          tx_wait  <= 1'b0;
          if (rx_done) begin
            if (rx_data == OP_R || rx_data == OP_W) begin
              op_wr <= (rx_data == OP_W);
              state <= S_ADDR;
            end else begin
              resp_sr   <= {RSP_BAD, 32'h0};
              resp_left <= 3'd1;
              state     <= S_RESP;
            end
          end
        end

        // A byte arriving on the expiry cycle wins over the gap timeout.
        S_ADDR, S_DATA: begin
          if (rx_done) begin
            gap_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_ADDR) addr_sr <= {addr_sr[23:0], rx_data};
            else                 data_sr <= {data_sr[23:0], rx_data};
            if (byte_cnt == 2'd3) begin
              if (state == S_ADDR && op_wr) begin
                state <= S_DATA;
              end else begin
                state   <= S_BUS;
                STB     <= 1'b1;
                WE      <= op_wr;
                ack_cnt <= '0;
                ADDR    <= (state == S_ADDR) ? {addr_sr[23:0], rx_data} : addr_sr;
                DAT_O   <= (state == S_DATA) ? {data_sr[23:0], rx_data} : 32'h0;
              end
            end
          end else if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_BUS: begin
          if (ACK || ack_cnt == ACK_LAST) begin
            STB   <= 1'b0;
            WE    <= 1'b0;
            ADDR  <= 32'h0;
            DAT_O <= 32'h0;
            state <= S_RESP;
            if (!ACK) begin
              resp_sr   <= {RSP_ERR, 32'h0};
              resp_left <= 3'd1;
            end else if (op_wr) begin
              resp_sr   <= {RSP_OK, 32'h0};
              resp_left <= 3'd1;
            end else begin
              resp_sr   <= {RSP_OK, DAT_I};
              resp_left <= 3'd5;
            end
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        // One byte in flight at a time; tx_data stays put until its tx_done.
        S_RESP: begin
          if (!tx_wait) begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= resp_sr[39:32];
              tx_wait  <= 1'b1;
            end
          end else if (tx_done) begin
            tx_wait   <= 1'b0;
            resp_sr   <= {resp_sr[31:0], 8'h0};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized bench for uart_bus_master with a frame-level reference model,
// a bus slave with selectable ACK behaviour and a UART transmitter model.
module tb_uart_bus_master;
  localparam int ACK_TO = 16;
  localparam int GAP_TO = 100;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        STB, WE;
  logic [31:0] ADDR, DAT_O, DAT_I;
  logic        ACK;
  logic        busy;

  int          ack_mode = 0;
  int          ack_delay = 1;
  logic [31:0] rd_val = 32'h0;

  int          stb_run = 0, stb_total = 0, unstable = 0, proto_err = 0;
  logic [31:0] f_addr = 32'h0, f_dat = 32'h0;
  logic        f_we = 1'b0;

  logic [7:0]  txq[$];
  logic        tx_out = 1'b0;
  logic        started = 1'b0;
  logic [7:0]  tx_byte = 8'h0;
  int          tx_cd = 0;

  int          checks = 0, failures = 0;

  uart_bus_master #(.ACK_TIMEOUT(ACK_TO), .RX_GAP_TIMEOUT(GAP_TO)) dut (
    .clk(clk), .RSTN(RSTN), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK(ACK),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: mode 0 ACK tied high, mode 1 ACK on the Nth STB-high cycle, mode 2 never.
  assign ACK   = (ack_mode == 0) ? 1'b1 :
                 (ack_mode == 1) ? (STB && stb_run == ack_delay) : 1'b0;
  assign DAT_I = STB ? rd_val : 32'h0;

  always @(negedge clk) begin
    if (STB) begin
      if (stb_run == 0) begin
        f_addr = ADDR; f_we = WE; f_dat = DAT_O;
      end else if (ADDR !== f_addr || WE !== f_we || DAT_O !== f_dat) begin
        unstable++;
      end
      stb_run++;
      stb_total++;
    end else begin
      stb_run = 0;
    end
  end

  // Transmitter: busy for a random few cycles after each start, then a tx_done pulse.
  always @(negedge clk) begin
    started = tx_start;
    if (tx_start && (tx_busy || tx_out)) proto_err++;
    if (tx_done) begin
      tx_done = 1'b0;
      tx_out  = 1'b0;
    end
    if (started) begin
      txq.push_back(tx_data);
      tx_byte = tx_data;
      tx_out  = 1'b1;
      tx_busy = 1'b1;
      tx_cd   = $urandom_range(2, 6);
    end else if (tx_busy) begin
      if (tx_data !== tx_byte) proto_err++;
      if (tx_cd == 0) begin
        tx_done = 1'b1;
        tx_busy = 1'b0;
      end else begin
        tx_cd--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Caller is at a negedge; returns one negedge later with rx_done low.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || tx_out) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s idle_wait got=busy exp=idle within 4000 cycles", nm);
    end
  endtask

  task automatic do_frame(input string nm, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int mode, input int dly,
                          input logic [31:0] rd, input int inject);
    int s0, u0, p0, t0, n, exp_stb;
    bit valid;
    logic [7:0] exq[$];
    ack_mode = mode; ack_delay = dly; rd_val = rd;
    s0 = stb_total; u0 = unstable; p0 = proto_err; t0 = txq.size();
    valid = (op == 8'h52) || (op == 8'h57);
    send_byte(op);
    if (valid) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(addr[31-8*i -: 8]);
      end
      if (op == 8'h57)
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_byte(wd[31-8*i -: 8]);
        end
    end
    if (inject == 1) begin
      n = 0;
      while (!STB && n < 50) begin @(negedge clk); n++; end
      send_byte(8'h55);
    end else if (inject == 2) begin
      n = 0;
      while (!tx_busy && n < 200) begin @(negedge clk); n++; end
      send_byte(8'h55);
    end
    wait_idle(nm);

    // Reference: what the frame must produce on the bus and on the UART.
    if (!valid) begin
      exp_stb = 0;
      exq.push_back(8'h3F);
    end else if (mode == 2) begin
      exp_stb = ACK_TO;
      exq.push_back(8'h45);
    end else begin
      exp_stb = (mode == 0) ? 1 : dly;
      exq.push_back(8'h4B);
      if (op == 8'h52)
        for (int i = 0; i < 4; i++) exq.push_back(rd[31-8*i -: 8]);
    end

    checks++;
    if (stb_total - s0 !== exp_stb) begin
      failures++;
      $display("FAIL %s stb_cycles got=%0d exp=%0d", nm, stb_total - s0, exp_stb);
    end
    if (exp_stb > 0) begin
      checks++;
      if (f_addr !== addr || f_we !== (op == 8'h57)) begin
        failures++;
        $display("FAIL %s bus_addr_we got=%h/%b exp=%h/%b", nm, f_addr, f_we, addr, op == 8'h57);
      end
      if (op == 8'h57) begin
        checks++;
        if (f_dat !== wd) begin
          failures++;
          $display("FAIL %s bus_dat_o got=%h exp=%h", nm, f_dat, wd);
        end
      end
      checks++;
      if (unstable != u0) begin
        failures++;
        $display("FAIL %s bus_stable got=%0d changes exp=0", nm, unstable - u0);
      end
    end
    checks++;
    if (txq.size() - t0 != exq.size()) begin
      failures++;
      $display("FAIL %s tx_count got=%0d exp=%0d", nm, txq.size() - t0, exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      if (t0 + i < txq.size()) begin
        checks++;
        if (txq[t0+i] !== exq[i]) begin
          failures++;
          $display("FAIL %s tx_byte[%0d] got=%h exp=%h", nm, i, txq[t0+i], exq[i]);
        end
      end
    end
    checks++;
    if (proto_err != p0) begin
      failures++;
      $display("FAIL %s tx_handshake got=%0d violations exp=0", nm, proto_err - p0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      rx_data = (i == 0) ? 8'h57 : 8'h00;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      checks++;
      if (STB !== 1'b0 || tx_start !== 1'b0 || busy !== 1'b0 || ADDR !== 32'h0 || tx_data !== 8'h0) begin
        failures++;
        $display("FAIL reset_outputs got=stb%b txs%b busy%b addr%h txd%h exp=all zero",
                 STB, tx_start, busy, ADDR, tx_data);
      end
    end
    RSTN = 1'b1;
    repeat (2) @(negedge clk);
    do_frame("reset_write", 8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 32'h0, 0);
  endtask

  task automatic test_read();
    do_frame("read_ack1", 8'h52, 32'h0000_0010, 32'h0, 0, 1, 32'h1234_5678, 0);
  endtask

  task automatic test_ack_timing();
    do_frame("delayed_ack7", 8'h57, 32'h0000_0123, 32'hCAFE_F00D, 1, 7, 32'h0, 0);
    do_frame("ack_timeout", 8'h52, 32'h0000_0040, 32'h0, 2, 1, 32'hAAAA_5555, 0);
  endtask

  task automatic test_bad_opcode();
    do_frame("bad_opcode", 8'h41, 32'h0, 32'h0, 0, 1, 32'h0, 0);
    do_frame("read_after_bad", 8'h52, 32'h0000_0020, 32'h0, 0, 1, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_gap_abort();
    int s0, t0;
    ack_mode = 0;
    s0 = stb_total; t0 = txq.size();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (GAP_TO - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_before_expiry busy got=%b exp=1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_at_expiry busy got=%b exp=0", busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (stb_total != s0 || txq.size() != t0) begin
      failures++;
      $display("FAIL gap_silent got=stb%0d tx%0d exp=stb0 tx0", stb_total - s0, txq.size() - t0);
    end
    do_frame("after_gap", 8'h57, 32'h8000_0003, 32'h0102_0304, 0, 1, 32'h0, 0);
  endtask

  task automatic test_ignored_bytes();
    do_frame("byte_in_resp", 8'h57, 32'h0000_0010, 32'h5555_AAAA, 0, 1, 32'h0, 2);
    do_frame("byte_in_bus", 8'h52, 32'h0000_0044, 32'h0, 1, 7, 32'h8765_4321, 1);
  endtask

  task automatic test_reset_in_bus();
    int n = 0, t0;
    ack_mode = 2;
    t0 = txq.size();
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    while (!STB && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (STB !== 1'b1) begin
      failures++;
      $display("FAIL rst_bus_start stb got=%b exp=1", STB);
    end
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if (STB !== 1'b0 || WE !== 1'b0 || ADDR !== 32'h0) begin
      failures++;
      $display("FAIL rst_bus_async got=stb%b addr%h exp=stb0 addr0", STB, ADDR);
    end
    repeat (3) @(negedge clk);
    RSTN = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (txq.size() != t0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_bus_no_resp got=tx%0d busy%b exp=tx0 busy0", txq.size() - t0, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0:       op = 8'h41;
        1, 2:    op = 8'h52;
        default: op = 8'h57;
      endcase
      do_frame("random", op, $urandom, $urandom, $urandom_range(0, 2),
               $urandom_range(1, 10), $urandom, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_ack_timing();
    test_bad_opcode();
    test_gap_abort();
    test_ignored_bytes();
    test_reset_in_bus();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
